freq_lock: RTL and testbench

- Downstream consumer of the FFT peak-frequency stage.
- Once per FFT frame it samples the stage's held frequency estimate `f_sample` in Hz, runs a 2^AVG_LOG2-frame moving average and qualifies lock with a consecutive-hit / consecutive-miss state machine.
- Outputs the smoothed frequency, a lock flag and an NCO frequency tuning word for the tracking loop.
- Frame boundary is the falling edge of the shared FFT output-valid `opd_o`. The upstream estimate is stable at that edge.

---
 rtl/freq_pkg.sv | 14 +
 rtl/mavg_buf.sv | 47 ++++
 rtl/freq_lock.sv | 154 +++++++++++++++
 tb/tb_freq_lock.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency-lock tracker.
package freq_pkg;

  localparam int FW = 32;
  localparam logic [FW-1:0] F_MAX_DEF   = 32'd500000;
  localparam logic [15:0]   FTW_MUL_DEF = 16'd4295;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/mavg_buf.sv
// Circular window of the last 2^AVG_LOG2 estimates with a running sum; avg is sum>>AVG_LOG2.
// preload fills every slot with din; clear has priority over preload, preload over push.
module mavg_buf
  import freq_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          preload,
  input  logic          push,
  input  logic          clear,
  input  logic [FW-1:0] din,
  output logic [FW-1:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = FW + AVG_LOG2;

  logic [FW-1:0]       mem [DEPTH];
  logic [AVG_LOG2-1:0] wptr;
  logic [SW-1:0]       sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      sum  <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      sum  <= '0;
    end else if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= din;
      wptr <= '0;
      sum  <= SW'(din) << AVG_LOG2;
    end else if (push) begin
      // Wide sum cannot overflow, so add-then-subtract is safe in any order.
      mem[wptr] <= din;
      wptr      <= wptr + AVG_LOG2'(1);
      sum       <= sum + SW'(din) - SW'(mem[wptr]);
    end
  end

  assign avg = sum[SW-1:AVG_LOG2];

endmodule

// File: rtl/freq_lock.sv
// Per-frame frequency averaging, hit/miss lock qualification and NCO tuning word generation.
// Optional FREQ_LOCK_OUTLIER_EN: large misses while LOCKED are counted but kept out of the average.
module freq_lock
  import freq_pkg::*;
#(
  parameter int            AVG_LOG2   = 3,
  parameter logic [FW-1:0] TOL        = 32'd2000,
  parameter int            LOCK_CNT   = 4,
  parameter int            UNLOCK_CNT = 3,
  parameter logic [FW-1:0] F_MAX      = F_MAX_DEF,
  parameter logic [23:0]   TIMEOUT    = 24'd4_000_000,
  parameter logic [15:0]   FTW_MUL    = FTW_MUL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] f_sample,
  input  logic          opd_o,
  output logic [FW-1:0] f_avg,
  output logic [FW-1:0] ftw,
  output logic          locked,
  output logic          est_vld,
  output logic [3:0]    miss_cnt
);

  state_t          state, state_nxt;
  logic            opd_q, strobe, cap_vld;
  logic [FW-1:0]   cap, avg;
  logic [3:0]      hit_cnt, hit_inc, miss_inc;
  logic [23:0]     tcnt;
  logic            to_hit, invalid, hit, outlier;
  logic            preload, push, clear;
  logic            upd1, upd2;
  logic signed [FW:0] diff;
  logic [FW:0]     adiff;

  assign strobe   = opd_q & ~opd_o;
  assign hit_inc  = hit_cnt + 4'd1;
  assign miss_inc = miss_cnt + 4'd1;

  assign invalid = cap > F_MAX;
  assign diff    = $signed({1'b0, cap}) - $signed({1'b0, f_avg});
  assign adiff   = diff[FW] ? (FW+1)'(-diff) : (FW+1)'(diff);
  assign hit     = !invalid && (adiff <= {1'b0, TOL});
`ifdef FREQ_LOCK_OUTLIER_EN
  assign outlier = {2'b00, adiff} > {1'b0, TOL, 2'b00};
`else
  assign outlier = 1'b0;
`endif

  // A capture in flight always beats an expiring timeout.
  assign to_hit = (state != IDLE) && (tcnt == TIMEOUT) && !strobe && !cap_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cap_vld) begin
      case (state)
        IDLE:    if (!invalid) state_nxt = ACQ;
        ACQ:     if (hit && hit_inc == 4'(LOCK_CNT)) state_nxt = LOCKED;
        LOCKED:  if (!hit && miss_inc == 4'(UNLOCK_CNT)) state_nxt = ACQ;
        default: state_nxt = IDLE;
      endcase
    end else if (to_hit) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    preload = 1'b0;
    push    = 1'b0;
    clear   = to_hit;
    if (cap_vld && !invalid) begin
      case (state)
        IDLE:    preload = 1'b1;
        ACQ:     push    = 1'b1;
        LOCKED:  push    = !outlier;
        default: push    = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (to_hit) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cap_vld) begin
      case (state)
        IDLE: if (!invalid) hit_cnt <= 4'd1;
        ACQ:  hit_cnt <= hit ? hit_inc : 4'd0;
        LOCKED: begin
          if (hit) begin
            miss_cnt <= '0;
          end else begin
            // The terminal count stays visible for one cycle, then clears outside LOCKED.
            miss_cnt <= miss_inc;
            if (miss_inc == 4'(UNLOCK_CNT)) hit_cnt <= '0;
          end
        end
        default: hit_cnt <= '0;
      endcase
    end else if (state != LOCKED) begin
      miss_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  tcnt <= '0;
    else if (state == IDLE || strobe || cap_vld) tcnt <= '0;
    else if (tcnt != TIMEOUT)                  tcnt <= tcnt + 24'd1;
  end

  mavg_buf #(.AVG_LOG2(AVG_LOG2)) u_mavg (
    .clk     (clk),
    .rst     (rst),
    .preload (preload),
    .push    (push),
    .clear   (clear),
    .din     (cap),
    .avg     (avg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opd_q   <= 1'b0;
      cap     <= '0;
      cap_vld <= 1'b0;
      upd1    <= 1'b0;
      upd2    <= 1'b0;
      f_avg   <= '0;
      ftw     <= '0;
      est_vld <= 1'b0;
      locked  <= 1'b0;
    end else begin
      opd_q   <= opd_o;
      cap_vld <= strobe;
      if (strobe) cap <= f_sample;
      upd1    <= preload | push;
      upd2    <= upd1;
      if (upd1) f_avg <= avg;
      // Only the low 32 bits of the 48-bit product are kept, so a 32-bit multiply suffices.
      if (upd2) ftw <= f_avg * {16'd0, FTW_MUL};
      est_vld <= upd2;
      locked  <= (state == LOCKED);
    end
  end

endmodule

// File: tb/tb_freq_lock.sv
// Directed bench for freq_lock; short TIMEOUT keeps the idle-timeout scenario brief.
module tb_freq_lock;
  import freq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] f_sample = '0;
  logic        opd_o = 1'b0;
  logic [31:0] f_avg, ftw;
  logic        locked, est_vld;
  logic [3:0]  miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [23:0] TB_TIMEOUT = 24'd200;

  freq_lock #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_sample (f_sample),
    .opd_o    (opd_o),
    .f_avg    (f_avg),
    .ftw      (ftw),
    .locked   (locked),
    .est_vld  (est_vld),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // Observations after each stage edge: E1 (state), E2 (f_avg/locked), E3 (ftw/est_vld).
  logic [3:0]  o_m1, o_m2;
  logic [1:0]  o_s1;
  logic        o_l1, o_l2, o_v2, o_v3;
  logic [31:0] o_a2, o_w3;

  task automatic send_frame(input logic [31:0] f);
    @(negedge clk);
    f_sample = f;
    opd_o    = 1'b1;
    repeat (4) @(negedge clk);
    opd_o = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    o_m1 = miss_cnt; o_s1 = dut.state; o_l1 = locked;
    @(posedge clk); #1;
    o_l2 = locked; o_a2 = f_avg; o_v2 = est_vld; o_m2 = miss_cnt;
    @(posedge clk); #1;
    o_v3 = est_vld; o_w3 = ftw;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if ({f_avg, ftw, locked, est_vld, miss_cnt} !== '0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", {f_avg, ftw, locked, est_vld, miss_cnt}); end
    n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dut.state, IDLE); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    send_frame(32'd100000);
    n_tests++; if (o_s1 !== ACQ) begin n_fail++; $display("FAIL single_state got %0d exp %0d", o_s1, ACQ); end
    n_tests++; if (o_v2 !== 1'b0) begin n_fail++; $display("FAIL single_vld_early got %b exp 0", o_v2); end
    n_tests++; if (o_v3 !== 1'b1) begin n_fail++; $display("FAIL single_vld_t3 got %b exp 1", o_v3); end
    n_tests++; if (o_a2 !== 32'd100000) begin n_fail++; $display("FAIL single_favg got %0d exp 100000", o_a2); end
    n_tests++; if (o_w3 !== 32'd429500000) begin n_fail++; $display("FAIL single_ftw got %0d exp 429500000", o_w3); end
    n_tests++; if (o_l2 !== 1'b0) begin n_fail++; $display("FAIL single_locked got %b exp 0", o_l2); end
  endtask

  task automatic test_lock();
    send_frame(32'd100500);
    n_tests++; if (o_a2 !== 32'd100062) begin n_fail++; $display("FAIL lock_favg2 got %0d exp 100062", o_a2); end
    n_tests++; if (o_w3 !== 32'd429766290) begin n_fail++; $display("FAIL lock_ftw2 got %0d exp 429766290", o_w3); end
    send_frame(32'd99800);
    n_tests++; if (o_a2 !== 32'd100037) begin n_fail++; $display("FAIL lock_favg3 got %0d exp 100037", o_a2); end
    n_tests++; if (o_l2 !== 1'b0) begin n_fail++; $display("FAIL lock_early got %b exp 0", o_l2); end
    send_frame(32'd100200);
    n_tests++; if (o_s1 !== LOCKED) begin n_fail++; $display("FAIL lock_state got %0d exp %0d", o_s1, LOCKED); end
    n_tests++; if (o_l1 !== 1'b0 || o_l2 !== 1'b1) begin n_fail++; $display("FAIL lock_timing got t1=%b t2=%b exp t1=0 t2=1", o_l1, o_l2); end
    n_tests++; if (o_a2 !== 32'd100062) begin n_fail++; $display("FAIL lock_favg4 got %0d exp 100062", o_a2); end
  endtask

  task automatic test_invalid();
    send_frame(32'hFFFF_F830);
    n_tests++; if (o_m1 !== 4'd1) begin n_fail++; $display("FAIL invalid_miss got %0d exp 1", o_m1); end
    n_tests++; if (o_v2 !== 1'b0 || o_v3 !== 1'b0) begin n_fail++; $display("FAIL invalid_vld got %b%b exp 00", o_v2, o_v3); end
    n_tests++; if (o_a2 !== 32'd100062 || o_l2 !== 1'b1) begin n_fail++; $display("FAIL invalid_hold got favg=%0d locked=%b exp 100062/1", o_a2, o_l2); end
    send_frame(32'd100000);
    n_tests++; if (o_m1 !== 4'd0 || o_v3 !== 1'b1) begin n_fail++; $display("FAIL hit_clear got miss=%0d vld=%b exp 0/1", o_m1, o_v3); end
    n_tests++; if (o_a2 !== 32'd100062) begin n_fail++; $display("FAIL hit_favg got %0d exp 100062", o_a2); end
  endtask

  task automatic test_timeout();
    repeat (150) @(negedge clk);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL timeout_early got %b exp 1", locked); end
    repeat (100) @(negedge clk);
    n_tests++; if (locked !== 1'b0 || dut.state !== IDLE) begin n_fail++; $display("FAIL timeout_exit got locked=%b state=%0d exp 0/%0d", locked, dut.state, IDLE); end
    n_tests++; if (f_avg !== 32'd100062 || ftw !== 32'd429766290) begin n_fail++; $display("FAIL timeout_hold got %0d/%0d exp 100062/429766290", f_avg, ftw); end
    send_frame(32'd50000);
    n_tests++; if (o_s1 !== ACQ || o_a2 !== 32'd50000) begin n_fail++; $display("FAIL timeout_preload got state=%0d favg=%0d exp %0d/50000", o_s1, o_a2, ACQ); end
    n_tests++; if (o_w3 !== 32'd214750000) begin n_fail++; $display("FAIL timeout_ftw got %0d exp 214750000", o_w3); end
    for (int i = 0; i < 3; i++) send_frame(32'd50000);
    n_tests++; if (o_l2 !== 1'b1) begin n_fail++; $display("FAIL relock got %b exp 1", o_l2); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); opd_o = 1'b1; f_sample = 32'd50000;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    n_tests++; if ({f_avg, ftw, locked, est_vld, miss_cnt} !== '0) begin n_fail++; $display("FAIL reset_mid got %h exp 0", {f_avg, ftw, locked, est_vld, miss_cnt}); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(32'd50000);
    n_tests++; if (o_s1 !== ACQ || o_a2 !== 32'd50000 || o_v3 !== 1'b1) begin n_fail++; $display("FAIL reset_first got state=%0d favg=%0d vld=%b exp %0d/50000/1", o_s1, o_a2, o_v3, ACQ); end
    for (int i = 0; i < 3; i++) send_frame(32'd50000);
    n_tests++; if (o_l2 !== 1'b1) begin n_fail++; $display("FAIL reset_relock got %b exp 1", o_l2); end
  endtask

  task automatic test_unlock();
    logic [31:0] exp_avg [3];
    logic        exp_push;
`ifdef FREQ_LOCK_OUTLIER_EN
    exp_avg = '{32'd50000, 32'd50000, 32'd50000};
    exp_push = 1'b0;
`else
    exp_avg = '{32'd81250, 32'd112500, 32'd143750};
    exp_push = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      send_frame(32'd300000);
      n_tests++; if (o_m1 !== 4'(i + 1)) begin n_fail++; $display("FAIL unlock_miss%0d got %0d exp %0d", i, o_m1, i + 1); end
      n_tests++; if (o_a2 !== exp_avg[i] || o_v3 !== exp_push) begin n_fail++; $display("FAIL unlock_avg%0d got %0d vld=%b exp %0d vld=%b", i, o_a2, o_v3, exp_avg[i], exp_push); end
      n_tests++; if (o_l2 !== (i < 2)) begin n_fail++; $display("FAIL unlock_locked%0d got %b exp %b", i, o_l2, i < 2); end
    end
    n_tests++; if (o_s1 !== ACQ || o_m2 !== 4'd0) begin n_fail++; $display("FAIL unlock_exit got state=%0d miss=%0d exp %0d/0", o_s1, o_m2, ACQ); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lock();
    test_invalid();
    test_timeout();
    test_reset_mid();
    test_unlock();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired got running exp finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
